// File: rtl/gaus_rng_pkg.sv
// Shared types and fixed-point constants for the Gaussian RNG datapath.
// Covers the radius/trig Q formats, the output pair and the serializer state.
package gaus_rng_pkg;

  localparam int RAD_W     = 18;                    // radius, unsigned Q3.15
  localparam int RAD_FRAC  = 15;
  localparam int TRIG_W    = 18;                    // cos/sin, signed Q2.16
  localparam int TRIG_FRAC = 16;
  localparam int PROD_FRAC = RAD_FRAC + TRIG_FRAC;  // 31
  localparam int MUL_W     = RAD_W + 1;             // both operands widened to 19 bits
  localparam int PROD_W    = 2 * MUL_W;             // signed Q5.31 product
  localparam int SMP_W     = 16;                    // stored sample width

  typedef struct packed {
    logic signed [SMP_W-1:0] x;
    logic signed [SMP_W-1:0] y;
  } bm_pair_t;

  typedef enum logic {
    S_X = 1'b0,
    S_Y = 1'b1
  } ser_state_e;

endpackage

// File: rtl/gaus_bm_fifo.sv
// Synchronous show-ahead FIFO: rd_dat_o always shows the head entry.
// Exposes an occupancy count so the parent can do credit accounting.
module gaus_bm_fifo #(
  parameter int DEPTH = 16,
  parameter int W     = 32
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       wr_en_i,
  input  logic [W-1:0]               wr_dat_i,
  input  logic                       rd_en_i,
  output logic [W-1:0]               rd_dat_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     used_o
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   used_q, used_d;
  logic          full, wr_ok, rd_ok;

  assign full  = (used_q == (AW+1)'(DEPTH));
  assign wr_ok = wr_en_i && !full;
  assign rd_ok = rd_en_i && !empty_o;

  always_comb begin
    used_d = used_q;
    if (wr_ok && !rd_ok)      used_d = used_q + (AW+1)'(1);
    else if (!wr_ok && rd_ok) used_d = used_q - (AW+1)'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      used_q   <= '0;
    end else begin
      if (wr_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (rd_ok) rd_ptr_q <= rd_ptr_q + AW'(1);
      used_q <= used_d;
    end
  end

  // Storage carries no reset; the pointers alone define what is valid.
  always_ff @(posedge clk_i) begin
    if (wr_ok) mem_q[wr_ptr_q] <= wr_dat_i;
  end

  assign rd_dat_o = mem_q[rd_ptr_q];
  assign empty_o  = (used_q == '0);
  assign used_o   = used_q;

endmodule

// File: rtl/gaus_bm_mult.sv
// Box-Muller output stage: radius x cos/sin, round/saturate, pair FIFO and
// a serializer that emits x then y per pair; requests are credit-gated.
module gaus_bm_mult
  import gaus_rng_pkg::*;
#(
  parameter int pCORDIC_LAT = 5,
  parameter int pFIFO_DEPTH = 16,
  parameter int pDAT_W      = 16,
  parameter int pFRAC_W     = 11
) (
  input  logic              iclk,
  input  logic              ireset,
  input  logic              ival,
  input  logic [RAD_W-1:0]  iradius,
  output logic              ordy,
  input  logic [TRIG_W-1:0] icos,
  input  logic [TRIG_W-1:0] isin,
  output logic              oval,
  output logic [pDAT_W-1:0] odat,
  output logic              oidx,
  input  logic              iready
);
  localparam int L  = pCORDIC_LAT;
  localparam int CW = $clog2(pFIFO_DEPTH) + 1;
  localparam int SH = PROD_FRAC - pFRAC_W;

  localparam logic signed [PROD_W:0] RND_HALF = (PROD_W+1)'(1) << (SH - 1);
  localparam logic signed [PROD_W:0] SAT_MAX  = (PROD_W+1)'((2 ** (pDAT_W - 1)) - 1);
  localparam logic signed [PROD_W:0] SAT_MIN  = ~SAT_MAX;

  // Half-up rounding: bias by half an output LSB, then floor via arithmetic shift.
  function automatic logic signed [pDAT_W-1:0] rnd_sat(input logic signed [PROD_W-1:0] p);
    logic signed [PROD_W:0] s;
    s = (PROD_W+1)'(p) + RND_HALF;
    s = s >>> SH;
    if (s > SAT_MAX)      return SAT_MAX[pDAT_W-1:0];
    else if (s < SAT_MIN) return SAT_MIN[pDAT_W-1:0];
    else                  return s[pDAT_W-1:0];
  endfunction

  // vld_pipe_q[0..L-1]: cordic alignment, [L]: product, [L+1]: rounded pair.
  logic [L+1:0]            vld_pipe_q;
  logic [L-1:0][RAD_W-1:0] rad_q;
  logic                    acc, tap_vld, fifo_wr;

  assign acc     = ival && ordy;
  assign tap_vld = vld_pipe_q[L-1];
  assign fifo_wr = vld_pipe_q[L+1];

  always_ff @(posedge iclk or negedge ireset) begin
    if (!ireset) begin
      vld_pipe_q <= '0;
      rad_q      <= '0;
    end else begin
      vld_pipe_q <= {vld_pipe_q[L:0], acc};
      rad_q[0]   <= iradius;
      for (int i = 1; i < L; i++) rad_q[i] <= rad_q[i-1];
    end
  end

  logic signed [MUL_W-1:0]  rad_ext, cos_ext, sin_ext;
  logic signed [PROD_W-1:0] prod_x_q, prod_y_q;

  assign rad_ext = {1'b0, rad_q[L-1]};
  assign cos_ext = {icos[TRIG_W-1], icos};
  assign sin_ext = {isin[TRIG_W-1], isin};

  always_ff @(posedge iclk or negedge ireset) begin
    if (!ireset) begin
      prod_x_q <= '0;
      prod_y_q <= '0;
    end else if (tap_vld) begin
      prod_x_q <= PROD_W'(rad_ext) * PROD_W'(cos_ext);
      prod_y_q <= PROD_W'(rad_ext) * PROD_W'(sin_ext);
    end
  end

  bm_pair_t rnd_q;

  always_ff @(posedge iclk or negedge ireset) begin
    if (!ireset) begin
      rnd_q <= '0;
    end else if (vld_pipe_q[L]) begin
      rnd_q.x <= SMP_W'(rnd_sat(prod_x_q));
      rnd_q.y <= SMP_W'(rnd_sat(prod_y_q));
    end
  end

  bm_pair_t      head;
  logic          fifo_empty, pop;
  logic [CW-1:0] fifo_used;

  gaus_bm_fifo #(
    .DEPTH (pFIFO_DEPTH),
    .W     ($bits(bm_pair_t))
  ) u_fifo (
    .clk_i    (iclk),
    .rst_ni   (ireset),
    .wr_en_i  (fifo_wr),
    .wr_dat_i (rnd_q),
    .rd_en_i  (pop),
    .rd_dat_o (head),
    .empty_o  (fifo_empty),
    .used_o   (fifo_used)
  );

  // Credit: buffered pairs plus requests still in the pipe must fit the FIFO.
  logic [CW-1:0] inflight_q, inflight_d;
  logic [CW:0]   credit_sum;

  always_comb begin
    inflight_d = inflight_q;
    if (acc && !fifo_wr)      inflight_d = inflight_q + CW'(1);
    else if (!acc && fifo_wr) inflight_d = inflight_q - CW'(1);
  end

  always_ff @(posedge iclk or negedge ireset) begin
    if (!ireset) inflight_q <= '0;
    else         inflight_q <= inflight_d;
  end

  assign credit_sum = {1'b0, fifo_used} + {1'b0, inflight_q};
  assign ordy       = credit_sum < (CW+1)'(pFIFO_DEPTH);

  ser_state_e state_q, state_d;

  always_ff @(posedge iclk or negedge ireset) begin
    if (!ireset) state_q <= S_X;
    else         state_q <= state_d;
  end

  // The head entry is popped only after its y sample is taken.
  always_comb begin
    state_d = state_q;
    oval    = 1'b0;
    odat    = '0;
    oidx    = 1'b0;
    pop     = 1'b0;
    case (state_q)
      S_X: begin
        if (!fifo_empty) begin
          oval = 1'b1;
          odat = pDAT_W'(head.x);
          if (iready) state_d = S_Y;
        end
      end
      S_Y: begin
        oval = 1'b1;
        odat = pDAT_W'(head.y);
        oidx = 1'b1;
        if (iready) begin
          pop     = 1'b1;
          state_d = S_X;
        end
      end
      default: state_d = S_X;
    endcase
  end

endmodule

// File: tb/tb_gaus_bm_mult.sv
// Scoreboard bench for gaus_bm_mult with a fixed-latency cordic model.
// Expected samples come from an integer floor-based rounding model.
module tb_gaus_bm_mult;
  localparam int LAT = 5;

  logic        iclk = 1'b0;
  logic        ireset, ival, ordy, oval, oidx, iready;
  logic [17:0] iradius, icos, isin;
  logic [15:0] odat;

  always #5 iclk = ~iclk;

  gaus_bm_mult #(
    .pCORDIC_LAT (LAT),
    .pFIFO_DEPTH (16),
    .pDAT_W      (16),
    .pFRAC_W     (11)
  ) dut (
    .iclk    (iclk),
    .ireset  (ireset),
    .ival    (ival),
    .iradius (iradius),
    .ordy    (ordy),
    .icos    (icos),
    .isin    (isin),
    .oval    (oval),
    .odat    (odat),
    .oidx    (oidx),
    .iready  (iready)
  );

  typedef struct { int due; logic [17:0] c; logic [17:0] s; } cord_t;
  typedef struct { bit idx; logic [15:0] d; } exp_t;

  cord_t cq[$];
  exp_t  sb[$];
  exp_t  mon_e;

  int n_cmp = 0, n_err = 0;
  int cyc = 0, n_acc = 0, acc_cyc = 0, rise_cyc = -1;
  bit ordy_s, oval_s;
  bit prev_stall = 0, prev_oval = 0, stall_idx = 0;
  logic [15:0] stall_dat = '0;

  // Round-half-up of r*c/2^20 using floor division, then clamp to int16.
  function automatic logic [15:0] ref_bm(input logic [17:0] r, input logic [17:0] c);
    longint p, q, v;
    p = longint'(r) * longint'($signed(c));
    q = p + 64'sd524288;
    if (q >= 0) v = q / 1048576;
    else        v = -((-q + 1048575) / 1048576);
    if (v > 32767)  v = 32767;
    if (v < -32768) v = -32768;
    return 16'(v);
  endfunction

  task automatic check(input string nm, input longint act, input longint expv);
    n_cmp++;
    if (act != expv) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d", nm, act, expv);
    end
  endtask

  task automatic drive_cordic();
    if (cq.size() > 0 && cq[0].due == cyc) begin
      icos = cq[0].c;
      isin = cq[0].s;
      void'(cq.pop_front());
    end else begin
      icos = 18'($urandom);
      isin = 18'($urandom);
    end
  endtask

  // One cycle, entered and left 1 time unit after a rising edge.
  task automatic step(input bit v, input logic [17:0] r, input logic [17:0] c,
                      input logic [17:0] s, input bit rdy, input bit use_e,
                      input logic [15:0] ex, input logic [15:0] ey);
    ival = v; iradius = r; iready = rdy;
    @(negedge iclk);
    ordy_s = ordy; oval_s = oval;
    if (ival && ordy && ireset) begin
      n_acc++;
      acc_cyc = cyc;
      cq.push_back('{cyc + LAT, c, s});
      sb.push_back('{1'b0, use_e ? ex : ref_bm(r, c)});
      sb.push_back('{1'b1, use_e ? ey : ref_bm(r, s)});
    end
    @(posedge iclk); #1;
    cyc++;
    drive_cordic();
  endtask

  task automatic idle(input bit rdy, input int n);
    repeat (n) step(1'b0, '0, '0, '0, rdy, 1'b0, '0, '0);
  endtask

  task automatic rnd_req(input bit v, input bit rdy);
    step(v, 18'($urandom), 18'($urandom), 18'($urandom), rdy, 1'b0, '0, '0);
  endtask

  task automatic do_reset(input int n);
    ival = 0; iready = 0; ireset = 0;
    sb.delete(); cq.delete();
    repeat (n) begin
      @(negedge iclk);
      check("rst_oval", oval, 0);
      check("rst_odat", odat, 0);
      check("rst_oidx", oidx, 0);
      @(posedge iclk); #1;
      cyc++;
      drive_cordic();
    end
    ireset = 1;
  endtask

  // Monitor: compare every accepted sample and the hold behaviour while stalled.
  always @(negedge iclk) begin
    if (!ireset) begin
      prev_stall = 0;
      prev_oval  = 0;
    end else begin
      if (prev_stall) begin
        n_cmp++;
        if (!(oval && odat == stall_dat && oidx == stall_idx)) begin
          n_err++;
          $display("FAIL hold: oval=%0b odat=%h oidx=%0b want 1 %h %0b",
                   oval, odat, oidx, stall_dat, stall_idx);
        end
      end
      if (oval && !prev_oval) rise_cyc = cyc;
      prev_oval = oval;
      if (oval && iready) begin
        n_cmp++;
        if (sb.size() == 0) begin
          n_err++;
          $display("FAIL extra_sample: odat=%h oidx=%0b want no output", odat, oidx);
        end else begin
          mon_e = sb.pop_front();
          if (odat !== mon_e.d || oidx !== mon_e.idx) begin
            n_err++;
            $display("FAIL sample: odat=%h oidx=%0b want %h %0b", odat, oidx, mon_e.d, mon_e.idx);
          end
        end
      end
      prev_stall = oval && !iready;
      stall_dat  = odat;
      stall_idx  = oidx;
    end
  end

  initial begin
    int g0;
    ireset = 0; ival = 0; iready = 0; iradius = '0; icos = '0; isin = '0;
    @(posedge iclk); #1;
    do_reset(3);

    // Directed vectors: unity, saturation both ways, rounding.
    step(1, 18'h08000, 18'h10000, 18'h00000, 1, 1, 16'h0800, 16'h0000);
    check("rel_ordy", ordy_s, 1);
    idle(1, 12);
    check("latency", rise_cyc - acc_cyc, 8);
    step(1, 18'h3FFFF, 18'h1FFFF, 18'h20000, 1, 1, 16'h7FFF, 16'h8000);
    step(1, 18'h00001, 18'h10000, 18'h00000, 1, 1, 16'h0000, 16'h0000);
    step(1, 18'h00010, 18'h08000, 18'h3FFFF, 1, 1, 16'h0001, 16'h0000);
    idle(1, 20);
    check("dir_drained", sb.size(), 0);

    // Fill with output stalled: exactly DEPTH grants, then credit exhausted.
    g0 = n_acc;
    repeat (40) rnd_req(1, 0);
    check("grants", n_acc - g0, 16);
    check("full_ordy", ordy_s, 0);
    idle(1, 1);
    check("ordy_before_pop_x", ordy_s, 0);
    idle(1, 1);
    check("ordy_at_pop", ordy_s, 0);
    idle(0, 1);
    check("ordy_after_pop", ordy_s, 1);
    idle(1, 40);
    check("full_drained", sb.size(), 0);

    // Random traffic with varying request and accept densities.
    for (int b = 0; b < 4; b++) begin
      int pv, pr, target, budget;
      pv = (b == 0) ? 90 : (b == 1) ? 50 : (b == 2) ? 20 : 100;
      pr = (b == 0) ? 60 : (b == 1) ? 95 : (b == 2) ? 30 : 100;
      target = n_acc + 1000;
      budget = 0;
      while (n_acc < target && budget < 12000) begin
        rnd_req(($urandom_range(99) < pv), ($urandom_range(99) < pr));
        budget++;
      end
    end
    idle(1, 80);
    check("rand_drained", sb.size(), 0);

    // Reset with 4 pairs buffered and 3 requests in flight.
    repeat (4) rnd_req(1, 0);
    idle(0, 6);
    repeat (3) rnd_req(1, 0);
    do_reset(2);
    step(1, 18'h08000, 18'h10000, 18'h00000, 1, 1, 16'h0800, 16'h0000);
    check("rst_rel_ordy", ordy_s, 1);
    idle(1, 14);
    check("rst_latency", rise_cyc - acc_cyc, 8);
    check("rst_drained", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
